// File: rtl/rc4_key_scheduler.sv
// Parallel RC4 key-search controller: deals consecutive 24-bit keys to a pool of
// decrypt engines, latches the first matching key/plaintext and drives the draw handshake.
module rc4_key_scheduler #(
  parameter int          NUM_ENGINES = 4,
  parameter logic [23:0] KEY_START   = 24'h000000,
  parameter logic [23:0] KEY_LAST    = 24'hFFFFFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [NUM_ENGINES-1:0]     eng_enable,
  output logic [24*NUM_ENGINES-1:0]  eng_key,
  input  logic [NUM_ENGINES-1:0]     eng_done,
  input  logic [NUM_ENGINES-1:0]     eng_match,
  input  logic [128*NUM_ENGINES-1:0] eng_plaintext,
  output logic [15:0]                key_display,
  output logic                       stopwatch_run,
  output logic                       draw_plaintext,
  input  logic                       done_drawing_plaintext,
  output logic [127:0]               plaintext_to_draw,
  output logic [23:0]                found_key,
  output logic                       found,
  output logic                       exhausted
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    DRAW      = 3'd2,
    DONE      = 3'd3,
    EXHAUSTED = 3'd4
  } state_t;

  // One spare bit keeps the counter from wrapping when KEY_LAST is 24'hFFFFFF.
  localparam logic [24:0] KEY_START_EXT = {1'b0, KEY_START};
  localparam logic [24:0] KEY_LAST_EXT  = {1'b0, KEY_LAST};

  state_t                  state_r;
  logic [24:0]             next_key_r;
  logic [NUM_ENGINES-1:0]  enable_prev_r;

  logic                    keys_left_s;
  logic [NUM_ENGINES-1:0]  disp_oh_s;
  logic [NUM_ENGINES-1:0]  retire_s;
  logic                    win_s;
  logic [23:0]             win_key_s;
  logic [127:0]            win_pt_s;

  assign key_display = next_key_r[23:8];

  // Pick the lowest idle slot for dispatch and the lowest matching engine as winner.
  always_comb begin
    keys_left_s = (next_key_r <= KEY_LAST_EXT);
    disp_oh_s   = {NUM_ENGINES{1'b0}};
    retire_s    = {NUM_ENGINES{1'b0}};
    win_s       = 1'b0;
    win_key_s   = 24'h000000;
    win_pt_s    = 128'h0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      // A slot needs a full idle cycle (enable low now and last cycle) before reuse.
      if (keys_left_s && !eng_enable[i] && !enable_prev_r[i]) begin
        disp_oh_s    = {NUM_ENGINES{1'b0}};
        disp_oh_s[i] = 1'b1;
      end else begin
        disp_oh_s = disp_oh_s;
      end
      retire_s[i] = eng_enable[i] & eng_done[i] & ~eng_match[i];
      if (eng_enable[i] && eng_done[i] && eng_match[i]) begin
        win_s     = 1'b1;
        win_key_s = eng_key[24*i +: 24];
        win_pt_s  = eng_plaintext[128*i +: 128];
      end else begin
        win_s = win_s;
      end
    end
  end

  // Search FSM with registered engine controls, result latches and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r           <= IDLE;
      next_key_r        <= KEY_START_EXT;
      enable_prev_r     <= {NUM_ENGINES{1'b0}};
      eng_enable        <= {NUM_ENGINES{1'b0}};
      eng_key           <= {(24*NUM_ENGINES){1'b0}};
      plaintext_to_draw <= 128'h0;
      found_key         <= 24'h000000;
      stopwatch_run     <= 1'b0;
      draw_plaintext    <= 1'b0;
      found             <= 1'b0;
      exhausted         <= 1'b0;
    end else begin
      enable_prev_r <= eng_enable;
      case (state_r)
        IDLE, DONE, EXHAUSTED: begin
          if (start) begin
            state_r           <= RUN;
            next_key_r        <= KEY_START_EXT;
            found_key         <= 24'h000000;
            plaintext_to_draw <= 128'h0;
            stopwatch_run     <= 1'b1;
            draw_plaintext    <= 1'b0;
            found             <= 1'b0;
            exhausted         <= 1'b0;
          end
        end
        RUN: begin
          if (win_s) begin
            state_r           <= DRAW;
            found_key         <= win_key_s;
            plaintext_to_draw <= win_pt_s;
            eng_enable        <= {NUM_ENGINES{1'b0}};
            stopwatch_run     <= 1'b0;
            draw_plaintext    <= 1'b1;
            found             <= 1'b1;
          end else if (!keys_left_s && (eng_enable == {NUM_ENGINES{1'b0}})) begin
            state_r       <= EXHAUSTED;
            stopwatch_run <= 1'b0;
            exhausted     <= 1'b1;
          end else begin
            eng_enable <= (eng_enable & ~retire_s) | disp_oh_s;
            for (int i = 0; i < NUM_ENGINES; i++) begin
              if (disp_oh_s[i]) begin
                eng_key[24*i +: 24] <= next_key_r[23:0];
              end
            end
            if (disp_oh_s != {NUM_ENGINES{1'b0}}) begin
              next_key_r <= next_key_r + 25'd1;
            end
          end
        end
        DRAW: begin
          if (done_drawing_plaintext) begin
            state_r        <= DONE;
            draw_plaintext <= 1'b0;
          end
        end
        default: begin
          state_r        <= IDLE;
          eng_enable     <= {NUM_ENGINES{1'b0}};
          stopwatch_run  <= 1'b0;
          draw_plaintext <= 1'b0;
          found          <= 1'b0;
          exhausted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_key_scheduler.sv
// Directed bench for rc4_key_scheduler: two 2-engine instances (keys 0..5 and FFFFFE..FFFFFF)
// with behavioural engines and a dispatch-order scoreboard.
module tb_rc4_key_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic         start [2];
  logic         ddone [2];
  logic [1:0]   en    [2];
  logic [47:0]  keys  [2];
  logic [1:0]   edone [2];
  logic [1:0]   ematch[2];
  logic [255:0] ept   [2];
  logic [15:0]  kdisp [2];
  logic         sw    [2];
  logic         draw  [2];
  logic         fnd   [2];
  logic         exh   [2];
  logic [127:0] ptd   [2];
  logic [23:0]  fkey  [2];

  logic [7:0]   mask [2];
  logic         sync_mode;
  int           cnt [2][2];
  logic [1:0]   prev1 [2] = '{2'b00, 2'b00};
  logic [1:0]   prev2 [2] = '{2'b00, 2'b00};
  int           draw_cnt = 0;
  logic [23:0]  exp_q [$];
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  rc4_key_scheduler #(.NUM_ENGINES(2), .KEY_START(24'h000000), .KEY_LAST(24'h000005)) dut_a (
    .clk(clk), .reset(reset), .start(start[0]), .eng_enable(en[0]), .eng_key(keys[0]),
    .eng_done(edone[0]), .eng_match(ematch[0]), .eng_plaintext(ept[0]), .key_display(kdisp[0]),
    .stopwatch_run(sw[0]), .draw_plaintext(draw[0]), .done_drawing_plaintext(ddone[0]),
    .plaintext_to_draw(ptd[0]), .found_key(fkey[0]), .found(fnd[0]), .exhausted(exh[0]));

  rc4_key_scheduler #(.NUM_ENGINES(2), .KEY_START(24'hFFFFFE), .KEY_LAST(24'hFFFFFF)) dut_b (
    .clk(clk), .reset(reset), .start(start[1]), .eng_enable(en[1]), .eng_key(keys[1]),
    .eng_done(edone[1]), .eng_match(ematch[1]), .eng_plaintext(ept[1]), .key_display(kdisp[1]),
    .stopwatch_run(sw[1]), .draw_plaintext(draw[1]), .done_drawing_plaintext(ddone[1]),
    .plaintext_to_draw(ptd[1]), .found_key(fkey[1]), .found(fnd[1]), .exhausted(exh[1]));

  function automatic logic [127:0] pt_of(input logic [23:0] k);
    return {104'h41414141414141414141414141, k};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_for(input int d, input bit want_draw, input string tag);
    int n = 0;
    while (!(want_draw ? draw[d] : exh[d]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 128'(want_draw ? draw[d] : exh[d]), 128'd1);
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic pulse_ddone(input int d);
    ddone[d] = 1'b1;
    @(negedge clk);
    ddone[d] = 1'b0;
  endtask

  // Behavioural engines: done 3 cycles after enable (4 for key 4 in sync mode), match by mask.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 2; s++) begin
        logic [23:0] k;
        k = keys[d][24*s +: 24];
        ept[d][128*s +: 128] = pt_of(k);
        if (en[d][s] !== 1'b1) begin
          cnt[d][s]    = 0;
          edone[d][s]  = 1'b0;
          ematch[d][s] = 1'b0;
        end else if (!edone[d][s]) begin
          cnt[d][s]++;
          if (cnt[d][s] >= ((sync_mode && k == 24'd4) ? 4 : 3)) begin
            edone[d][s]  = 1'b1;
            ematch[d][s] = (k < 24'd8) && mask[d][k[2:0]];
          end
        end
      end
    end
  end

  // Scoreboard: every rising enable must carry the next expected key after an idle gap.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 2; s++) begin
        if (en[d][s] === 1'b1 && prev1[d][s] === 1'b0) begin
          check("idle_gap", 128'(prev2[d][s]), 128'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_dispatch", 128'(keys[d][24*s +: 24]), 128'hFFFF_FFFF);
          end else begin
            check("dispatch_key", 128'(keys[d][24*s +: 24]), 128'(exp_q.pop_front()));
          end
        end
      end
      prev2[d] = prev1[d];
      prev1[d] = en[d];
    end
    if (draw[0] === 1'b1) draw_cnt++;
  end

  initial begin
    int d0;
    reset     = 1'b1;
    start     = '{1'b0, 1'b0};
    ddone     = '{1'b0, 1'b0};
    mask      = '{8'h00, 8'h00};
    sync_mode = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_enable",   128'(en[0]),   128'd0);
    check("rst_key",      128'(keys[0]), 128'd0);
    check("rst_found_key",128'(fkey[0]), 128'd0);
    check("rst_plain",    ptd[0],        128'd0);
    check("rst_flags",    128'({sw[0], draw[0], fnd[0], exh[0]}), 128'd0);
    check("rst_display_b",128'(kdisp[1]), 128'hFFFF);
    reset = 1'b0;
    @(negedge clk);

    // Full sweep without a match
    for (int k = 0; k < 6; k++) exp_q.push_back(24'(k));
    d0 = draw_cnt;
    pulse_start(0);
    check("t1_run", 128'(sw[0]), 128'd1);
    wait_for(0, 1'b0, "t1_exhausted");
    check("t1_queue_empty", 128'(exp_q.size()), 128'd0);
    check("t1_flags", 128'({sw[0], draw[0], fnd[0]}), 128'd0);
    check("t1_no_draw", 128'(draw_cnt - d0), 128'd0);

    // Match on key 3 with start held high through RUN and DRAW
    mask[0] = 8'b0000_1000;
    for (int k = 0; k < 4; k++) exp_q.push_back(24'(k));
    start[0] = 1'b1;
    @(negedge clk);
    check("t2_run", 128'({sw[0], exh[0]}), 128'b10);
    wait_for(0, 1'b1, "t2_draw");
    check("t2_found_key", 128'(fkey[0]), 128'd3);
    check("t2_plain", ptd[0], pt_of(24'd3));
    check("t2_enables_off", 128'(en[0]), 128'd0);
    check("t2_found", 128'({fnd[0], sw[0]}), 128'b10);
    repeat (3) @(negedge clk);
    check("t2_draw_held", 128'(draw[0]), 128'd1);
    check("t2_queue_empty", 128'(exp_q.size()), 128'd0);
    start[0] = 1'b0;
    pulse_ddone(0);
    check("t2_draw_off", 128'(draw[0]), 128'd0);
    @(negedge clk);
    check("t2_done", 128'({fnd[0], sw[0], draw[0]}), 128'b100);
    check("t2_key_kept", 128'(fkey[0]), 128'd3);

    // Restart from DONE; keys 4 and 5 match in the same cycle
    mask[0]   = 8'b0011_0000;
    sync_mode = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back(24'(k));
    pulse_start(0);
    check("t3_cleared", 128'({fnd[0], fkey[0]}), 128'd0);
    check("t3_plain_cleared", ptd[0], 128'd0);
    wait_for(0, 1'b1, "t3_draw");
    check("t3_found_key", 128'(fkey[0]), 128'd4);
    check("t3_plain", ptd[0], pt_of(24'd4));
    check("t3_queue_empty", 128'(exp_q.size()), 128'd0);
    pulse_ddone(0);

    // Asynchronous reset in mid-search, then a clean restart
    mask[0]   = 8'h00;
    sync_mode = 1'b0;
    for (int k = 0; k < 6; k++) exp_q.push_back(24'(k));
    pulse_start(0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t4_async_enable", 128'(en[0]), 128'd0);
    check("t4_async_flags", 128'({sw[0], fnd[0]}), 128'd0);
    check("t4_display_b", 128'(kdisp[1]), 128'hFFFF);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    for (int k = 0; k < 6; k++) exp_q.push_back(24'(k));
    pulse_start(0);
    wait_for(0, 1'b0, "t4_exhausted");
    check("t4_queue_empty", 128'(exp_q.size()), 128'd0);

    // Top-of-space range: two keys, no wrap
    exp_q.push_back(24'hFFFFFE);
    exp_q.push_back(24'hFFFFFF);
    pulse_start(1);
    wait_for(1, 1'b0, "t5_exhausted");
    repeat (5) @(negedge clk);
    check("t5_queue_empty", 128'(exp_q.size()), 128'd0);
    check("t5_display", 128'(kdisp[1]), 128'h0000);
    check("t5_flags", 128'({fnd[1], sw[1], en[1]}), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
